// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (state encoding, default widths).
// Used by uart_receiver and uart_tx.
package uart_pkg;

  localparam int DEF_DIV_W  = 16;
  localparam int DEF_DATA_W = 8;
  localparam int MIN_DIV    = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-FF synchroniser with configurable reset value.
// Ports: clk, reset (async, low), d (async in), q (synchronised out).
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART deserialiser with valid/ready output.
// Optional even parity (8E1) when UART_RX_PARITY_EN is defined.
// Ports: clk, reset (async, low), div (cycles/bit), rxd (serial in),
//   rdy (downstream ready), dout/vld (byte out), frame_err, overrun.
import uart_pkg::*;

module uart_receiver #(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div,
  input  logic              rxd,
  input  logic              rdy,
  output logic [DATA_W-1:0] dout,
  output logic              vld,
  output logic              frame_err,
  output logic              overrun
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  state_t              state, state_n;
  logic [DIV_W-1:0]    cnt, cnt_n;
  logic [DIV_W-1:0]    divl, divl_n;
  logic [BW-1:0]       bits, bits_n;
  logic [DATA_W-1:0]   shift, shift_n;
  logic                par_err, par_n;
  logic                rxs, tick, done, bad;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxs)
  );

  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      divl    <= '0;
      bits    <= '0;
      shift   <= '0;
      par_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      divl    <= divl_n;
      bits    <= bits_n;
      shift   <= shift_n;
      par_err <= par_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    divl_n  = divl;
    bits_n  = bits;
    shift_n = shift;
    par_n   = par_err;
    done    = 1'b0;
    bad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = (div >> 1) - 1'b1;
          bits_n  = '0;
          par_n   = 1'b0;
        end
      end
      START: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (rxs) begin
          state_n = IDLE;
        end else begin
          divl_n  = div;
          cnt_n   = div - 1'b1;
          state_n = DATA;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shift_n = {rxs, shift[DATA_W-1:1]};
          cnt_n   = divl - 1'b1;
          bits_n  = bits + 1'b1;
          if (bits == LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          // even parity: data bits plus parity bit must xor to 0
          par_n   = (^shift) ^ rxs;
          cnt_n   = divl - 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (rxs) begin
          state_n = IDLE;
          if (par_err) bad = 1'b1;
          else         done = 1'b1;
        end else begin
          bad     = 1'b1;
          state_n = BREAK;
        end
      end
      BREAK: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout      <= '0;
      vld       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad;
      overrun   <= 1'b0;
      if (done) begin
        // a transfer this cycle frees the slot for the new byte
        if (!vld || rdy) begin
          dout <= shift;
          vld  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (vld && rdy) begin
        vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed self-checking bench for uart_receiver.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_receiver;

  localparam int DIV = 25;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] div;
  logic        rxd;
  logic        rdy;
  logic [7:0]  dout;
  logic        vld;
  logic        frame_err;
  logic        overrun;

  always #5 clk = ~clk;

  uart_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .div       (div),
    .rxd       (rxd),
    .rdy       (rdy),
    .dout      (dout),
    .vld       (vld),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int cmp_n = 0;
  int err_n = 0;

  task automatic check(input string tag, input int got, input int exp);
    cmp_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         cyc = 0;
  int         acc_n = 0;
  int         ferr_n = 0;
  int         ovr_n = 0;
  int         rise_cyc = 0;
  logic [7:0] acc_d = 8'h00;
  logic       vld_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (vld && rdy) begin
        acc_n++;
        acc_d = dout;
      end
      if (frame_err) ferr_n++;
      if (overrun) ovr_n++;
      if (vld && !vld_q) rise_cyc = cyc;
    end
    vld_q = vld;
  end

  task automatic bit_time(input logic b);
    rxd = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stp,
                      input logic pflip);
    logic pb;
    pb = (^d) ^ pflip;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(pb);
`endif
    bit_time(stp);
    rxd = 1'b1;
  endtask

  int a0, f0, o0, t0;

  initial begin
    reset = 1'b0;
    rxd   = 1'b1;
    rdy   = 1'b1;
    div   = 16'(DIV);
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_vld", vld, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 1: plain frame and latency
    a0 = acc_n; f0 = ferr_n; t0 = cyc;
    send(8'h55, 1'b1, 1'b0);
    repeat (DIV) @(negedge clk);
    check("t1_count", acc_n - a0, 1);
    check("t1_data", acc_d, 8'h55);
    check("t1_lat", int'((rise_cyc - t0) >= 236 && (rise_cyc - t0) <= 246), 1);
    check("t1_ferr", ferr_n - f0, 0);

    // 2: short glitch, then a good frame
    a0 = acc_n; f0 = ferr_n;
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("t2_glitch_vld", acc_n - a0, 0);
    check("t2_glitch_ferr", ferr_n - f0, 0);
    send(8'hA3, 1'b1, 1'b0);
    repeat (DIV) @(negedge clk);
    check("t2_count", acc_n - a0, 1);
    check("t2_data", acc_d, 8'hA3);

    // 3: bad stop, line held low, recovery
    a0 = acc_n; f0 = ferr_n;
    send(8'h3C, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (30 * DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("t3_ferr", ferr_n - f0, 1);
    check("t3_novld", acc_n - a0, 0);
    send(8'h81, 1'b1, 1'b0);
    repeat (DIV) @(negedge clk);
    check("t3_count", acc_n - a0, 1);
    check("t3_data", acc_d, 8'h81);

    // 4: backpressure and overrun
    a0 = acc_n; o0 = ovr_n;
    rdy = 1'b0;
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    repeat (DIV) @(negedge clk);
    check("t4_vld_held", vld, 1);
    check("t4_dout_held", dout, 8'h11);
    check("t4_ovr", ovr_n - o0, 1);
    check("t4_none_acc", acc_n - a0, 0);
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_acc", acc_n - a0, 1);
    check("t4_acc_data", acc_d, 8'h11);
    check("t4_vld_drop", vld, 0);

    // 5: reset mid-frame of 0xF0
    a0 = acc_n; f0 = ferr_n;
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_rst_dout", dout, 0);
    check("t5_rst_vld", vld, 0);
    @(negedge clk);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    send(8'h0F, 1'b1, 1'b0);
    repeat (DIV) @(negedge clk);
    check("t5_count", acc_n - a0, 1);
    check("t5_data", acc_d, 8'h0F);
    check("t5_ferr", ferr_n - f0, 0);

`ifdef UART_RX_PARITY_EN
    // 6: even parity good and bad
    a0 = acc_n; f0 = ferr_n;
    send(8'h07, 1'b1, 1'b0);
    repeat (DIV) @(negedge clk);
    check("t6_good_count", acc_n - a0, 1);
    check("t6_good_data", acc_d, 8'h07);
    check("t6_good_ferr", ferr_n - f0, 0);
    a0 = acc_n; f0 = ferr_n;
    send(8'h07, 1'b1, 1'b1);
    repeat (DIV) @(negedge clk);
    check("t6_bad_count", acc_n - a0, 0);
    check("t6_bad_ferr", ferr_n - f0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
